// File: rtl/fb_pkg.sv
// Shared types and constants for the frame buffer write path.
// Latency: n/a (package only).
// Backpressure: n/a.
//   Word packing: eight 8-bit palette indices per 64-bit word.
//   Lane 0 sits in bits [63:56]; lane 7 sits in bits [7:0].
package fb_pkg;

  localparam int H_RES          = 640;
  localparam int V_RES          = 480;
  localparam int WORDS_PER_LINE = 80;
  localparam int FB_WORDS       = 38400;
  localparam int PIX_PER_WORD   = 8;

  typedef logic [15:0] fb_addr_t;
  typedef logic [7:0]  pix_idx_t;

  typedef enum logic [2:0] {IDLE, HOLD, READ, RWAIT, WRITE, CLEAR} wr_state_t;

  // Replace the byte of a word that belongs to one pixel lane.
  function automatic logic [63:0] lane_put(input logic [63:0] word,
                                           input logic [2:0]  lane,
                                           input pix_idx_t    b);
    logic [63:0] r;
    r = word;
    // Lane L lives at bit offset 8*(7-L), and 7-L is simply ~L in 3 bits.
    r[{~lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Per-lane select: mask bit i picks new_w's lane i, otherwise old_w's.
  function automatic logic [63:0] lane_merge(input logic [63:0] new_w,
                                             input logic [63:0] old_w,
                                             input logic [7:0]  mask);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      r[8*(7-i) +: 8] = mask[i] ? new_w[8*(7-i) +: 8] : old_w[8*(7-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a pixel coordinate to its frame buffer word, byte lane and range flag.
// Latency: combinational.
// Backpressure: none.
//   i_x, i_y    : pixel column / row
//   o_addr      : y*80 + x[9:3]
//   o_lane      : x[2:0]
//   o_in_range  : x < H_RES and y < V_RES
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  output logic [15:0] o_addr,
  output logic [2:0]  o_lane,
  output logic        o_in_range
);

  logic [16:0] w_y_ext;
  logic [16:0] w_row_base;

  // y*80 built from two shifts: 80 = 64 + 16.
  assign w_y_ext    = {7'd0, i_y};
  assign w_row_base = (w_y_ext << 6) + (w_y_ext << 4);

  assign o_addr     = w_row_base[15:0] + {9'd0, i_x[9:3]};
  assign o_lane     = i_x[2:0];
  assign o_in_range = (i_x < 10'(H_RES)) && (i_y < 10'(V_RES));

endmodule

// File: rtl/frame_buffer_writer.sv
// Coalesces single-pixel writes into a one-word buffer, evicts by read-modify-write, and fills the frame on clear.
// Latency: eviction 3 cycles (READ, RWAIT, WRITE) or 1 cycle (WRITE) when all 8 lanes are dirty; clear 38400 write cycles.
// Backpressure: px_ready drops on a word change, a flush or clear request, and throughout eviction and clear.
//   Pixel port : px_valid/px_ready, px_x, px_y, px_index
//   Control    : flush_req/flush_done, clear_req/clear_index/clear_done, busy
//   Memory     : mem_addr, mem_rd, mem_rdata (one cycle after mem_rd), mem_wr, mem_wdata (all outputs registered)
module frame_buffer_writer
  import fb_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic [7:0]  px_index,
  input  logic        flush_req,
  output logic        flush_done,
  input  logic        clear_req,
  input  logic [7:0]  clear_index,
  output logic        clear_done,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [63:0] mem_rdata,
  output logic        mem_wr,
  output logic [63:0] mem_wdata
);

  wr_state_t   r_state, w_state_nxt;
  logic        r_alive;
  logic [15:0] r_buf_addr;
  logic [63:0] r_buf_data;
  logic [7:0]  r_buf_mask;
  logic        r_buf_vld;
  logic        r_flush_pend;
  logic [15:0] r_mem_addr;
  logic        r_mem_rd, r_mem_wr;
  logic [63:0] r_mem_wdata;
  logic        r_flush_done, r_clear_done;

  logic [15:0] w_px_addr;
  logic [2:0]  w_px_lane;
  logic        w_px_in_range;
  logic        w_same_word, w_take, w_load, w_merge, w_buf_clr, w_flush_pend_nxt;
  logic [15:0] w_mem_addr_nxt;
  logic        w_mem_rd_nxt, w_mem_wr_nxt, w_flush_done_nxt, w_clear_done_nxt;
  logic [63:0] w_mem_wdata_nxt;

  fb_addr_calc u_addr_calc (
    .i_x        (px_x),
    .i_y        (px_y),
    .o_addr     (w_px_addr),
    .o_lane     (w_px_lane),
    .o_in_range (w_px_in_range)
  );

  assign w_same_word = r_buf_vld && (w_px_addr == r_buf_addr);
  // Control requests outrank pixels, so no pixel is taken in a cycle carrying one.
  assign w_take      = r_alive && !clear_req && !flush_req;

  always_comb begin
    w_state_nxt      = r_state;
    px_ready         = 1'b0;
    w_load           = 1'b0;
    w_merge          = 1'b0;
    w_buf_clr        = 1'b0;
    w_flush_pend_nxt = r_flush_pend;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_rd_nxt     = 1'b0;
    w_mem_wr_nxt     = 1'b0;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_flush_done_nxt = 1'b0;
    w_clear_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        px_ready = w_take;
        if (flush_req) begin
          w_flush_done_nxt = 1'b1;             // nothing buffered: done next cycle
        end else if (px_valid && w_take && w_px_in_range) begin
          w_load      = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Out-of-range pixels are swallowed; a different word stalls the pixel.
        px_ready = w_take && (!w_px_in_range || w_same_word);
        if (flush_req || (px_valid && w_px_in_range && !w_same_word)) begin
          w_flush_pend_nxt = r_flush_pend | flush_req;
          w_mem_addr_nxt   = r_buf_addr;
          if (r_buf_mask == 8'hFF) begin
            // Every lane dirty: the old word is fully overwritten, skip the read.
            w_state_nxt     = WRITE;
            w_mem_wr_nxt    = 1'b1;
            w_mem_wdata_nxt = r_buf_data;
          end else begin
            w_state_nxt  = READ;
            w_mem_rd_nxt = 1'b1;
          end
        end else if (px_valid && px_ready && w_px_in_range) begin
          w_merge = 1'b1;
        end
      end
      READ: begin
        w_flush_pend_nxt = r_flush_pend | flush_req;
        w_state_nxt      = RWAIT;
      end
      RWAIT: begin
        // mem_rdata is valid now; fold it straight into the registered write word.
        w_flush_pend_nxt = r_flush_pend | flush_req;
        w_state_nxt      = WRITE;
        w_mem_wr_nxt     = 1'b1;
        w_mem_wdata_nxt  = lane_merge(r_buf_data, mem_rdata, r_buf_mask);
      end
      WRITE: begin
        w_state_nxt      = IDLE;
        w_buf_clr        = 1'b1;
        w_flush_done_nxt = r_flush_pend | flush_req;
        w_flush_pend_nxt = 1'b0;
      end
      CLEAR: begin
        if (r_mem_addr == 16'(FB_WORDS - 1)) begin
          w_state_nxt      = IDLE;
          w_clear_done_nxt = 1'b1;
          w_flush_done_nxt = r_flush_pend | flush_req;
          w_flush_pend_nxt = 1'b0;
        end else begin
          w_flush_pend_nxt = r_flush_pend | flush_req;
          w_mem_wr_nxt     = 1'b1;
          w_mem_addr_nxt   = r_mem_addr + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Clear wins over everything outside CLEAR: drop the buffer and any RMW.
    if (clear_req && (r_state != CLEAR)) begin
      w_state_nxt      = CLEAR;
      w_load           = 1'b0;
      w_merge          = 1'b0;
      w_buf_clr        = 1'b1;
      w_mem_addr_nxt   = '0;
      w_mem_rd_nxt     = 1'b0;
      w_mem_wr_nxt     = 1'b1;
      w_mem_wdata_nxt  = {8{clear_index}};
      w_flush_done_nxt = 1'b0;
      w_flush_pend_nxt = r_flush_pend | flush_req;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_alive      <= 1'b0;
      r_flush_pend <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_wdata  <= '0;
      r_flush_done <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_alive      <= 1'b1;
      r_flush_pend <= w_flush_pend_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_rd     <= w_mem_rd_nxt;
      r_mem_wr     <= w_mem_wr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_flush_done <= w_flush_done_nxt;
      r_clear_done <= w_clear_done_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_buf_vld  <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
      r_buf_mask <= '0;
    end else if (w_buf_clr) begin
      r_buf_vld  <= 1'b0;
      r_buf_mask <= '0;
    end else if (w_load) begin
      r_buf_vld  <= 1'b1;
      r_buf_addr <= w_px_addr;
      r_buf_data <= lane_put('0, w_px_lane, px_index);
      r_buf_mask <= 8'b1 << w_px_lane;
    end else if (w_merge) begin
      r_buf_data <= lane_put(r_buf_data, w_px_lane, px_index);
      r_buf_mask <= r_buf_mask | (8'b1 << w_px_lane);
    end
  end

  assign busy       = (r_state != IDLE);
  assign mem_addr   = r_mem_addr;
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;
  assign mem_wdata  = r_mem_wdata;
  assign flush_done = r_flush_done;
  assign clear_done = r_clear_done;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer: table of single-pixel RMW vectors, directed corner
// sequences (coalesce, clear, reset mid-RMW, out-of-range, last-write-wins) and a
// randomized pixel stream compared against a plain per-pixel frame model.
module tb_frame_buffer_writer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        px_valid = 1'b0;
  logic        px_ready;
  logic [9:0]  px_x = '0;
  logic [9:0]  px_y = '0;
  logic [7:0]  px_index = '0;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic        clear_req = 1'b0;
  logic [7:0]  clear_index = '0;
  logic        clear_done;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [63:0] mem_rdata = '0;
  logic        mem_wr;
  logic [63:0] mem_wdata;

  always #5 Clk = ~Clk;

  frame_buffer_writer dut (
    .Clk(Clk), .Reset(Reset), .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_index(px_index),
    .flush_req(flush_req), .flush_done(flush_done),
    .clear_req(clear_req), .clear_index(clear_index), .clear_done(clear_done),
    .busy(busy), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata)
  );

  // Frame RAM model with a backdoor preload port.
  logic [63:0] mem [0:38399];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [63:0] bd_data = '0;

  always @(posedge Clk) begin
    if (bd_we)  mem[bd_addr] <= bd_data;
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Bus monitor.
  int          n_wr = 0, n_rd = 0, n_fd = 0, n_cd = 0, clr_bad = 0, clr_cnt = 0;
  logic [15:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [63:0] last_wr_data = '0;
  logic        clr_mon = 1'b0;

  always @(posedge Clk) begin
    if (mem_wr) begin
      n_wr         <= n_wr + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wdata;
      if (clr_mon) begin
        if (mem_addr != 16'(clr_cnt) || mem_wdata != 64'h0707070707070707) clr_bad <= clr_bad + 1;
        clr_cnt <= clr_cnt + 1;
      end
    end
    if (mem_rd) begin
      n_rd         <= n_rd + 1;
      last_rd_addr <= mem_addr;
    end
    if (flush_done) n_fd <= n_fd + 1;
    if (clear_done) n_cd <= n_cd + 1;
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [63:0] d);
    @(negedge Clk); bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge Clk); bd_we = 1'b0;
  endtask

  // Presents a pixel until accepted; stalls = cycles with px_ready low, -1 if the bound expired.
  task automatic send_pixel(input logic [9:0] x, input logic [9:0] y, input logic [7:0] idx,
                            input int max_wait, output int stalls);
    stalls = 0;
    @(negedge Clk); px_valid = 1'b1; px_x = x; px_y = y; px_index = idx; #1;
    while (!px_ready && stalls < max_wait) begin
      stalls++;
      @(negedge Clk); #1;
    end
    if (!px_ready) stalls = -1;
    @(posedge Clk); #1; px_valid = 1'b0;
  endtask

  // One-cycle flush pulse; lat = cycles until flush_done is seen, -1 if none within the bound.
  task automatic do_flush(input int max_wait, output int lat);
    @(negedge Clk); flush_req = 1'b1;
    @(posedge Clk); #1; flush_req = 1'b0;
    lat = 0;
    do begin @(negedge Clk); lat++; end while (!flush_done && lat < max_wait);
    if (!flush_done) lat = -1;
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  idx;
    logic [63:0] pre;
    logic [15:0] exp_addr;
    logic [63:0] exp_data;
  } vec_t;

  vec_t        vt [6];
  logic [63:0] ref_w [0:3][0:7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls, lat, k, rd0, wr0, fd0, cd0, r;
    logic fd_at_cd, acc;
    logic [9:0] cur_x, cur_y;

    vt[0] = '{10'd41,  10'd0,   8'h3C, 64'hAAAAAAAAAAAAAAAA, 16'd5,     64'hAA3CAAAAAAAAAAAA};
    vt[1] = '{10'd0,   10'd0,   8'h5A, 64'h0000000000000000, 16'd0,     64'h5A00000000000000};
    vt[2] = '{10'd639, 10'd479, 8'hC3, 64'h1111111111111111, 16'd38399, 64'h11111111111111C3};
    vt[3] = '{10'd7,   10'd1,   8'h01, 64'hFFFFFFFFFFFFFFFF, 16'd80,    64'hFFFFFFFFFFFFFF01};
    vt[4] = '{10'd100, 10'd200, 8'h77, 64'h0123456789ABCDEF, 16'd16012, 64'h0123456777ABCDEF};
    vt[5] = '{10'd325, 10'd3,   8'hE1, 64'h0000000000000000, 16'd280,   64'h0000000000E10000};

    // Reset values.
    @(negedge Clk); @(negedge Clk);
    chk("rst_px_ready", 64'(px_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_done", 64'({flush_done, clear_done}), 64'd0);
    Reset = 1'b0; #1;
    chk("rst_release_px_ready", 64'(px_ready), 64'd0);
    @(negedge Clk);
    chk("rst_first_cycle_px_ready", 64'(px_ready), 64'd1);

    // Table: one pixel into a preloaded word, then flush.
    for (int i = 0; i < 6; i++) begin
      preload(vt[i].exp_addr, vt[i].pre);
      rd0 = n_rd; wr0 = n_wr; fd0 = n_fd;
      send_pixel(vt[i].x, vt[i].y, vt[i].idx, 10, stalls);
      chk($sformatf("v%0d_stalls", i), 64'(stalls), 64'd0);
      do_flush(20, lat);
      chk($sformatf("v%0d_flush_lat", i), 64'(lat), 64'd4);
      @(negedge Clk); @(negedge Clk);
      chk($sformatf("v%0d_n_rd", i), 64'(n_rd - rd0), 64'd1);
      chk($sformatf("v%0d_rd_addr", i), 64'(last_rd_addr), 64'(vt[i].exp_addr));
      chk($sformatf("v%0d_n_wr", i), 64'(n_wr - wr0), 64'd1);
      chk($sformatf("v%0d_wr_addr", i), 64'(last_wr_addr), 64'(vt[i].exp_addr));
      chk($sformatf("v%0d_wr_data", i), last_wr_data, vt[i].exp_data);
      chk($sformatf("v%0d_mem", i), mem[vt[i].exp_addr], vt[i].exp_data);
      chk($sformatf("v%0d_n_flush_done", i), 64'(n_fd - fd0), 64'd1);
    end

    // Flush with empty buffer.
    rd0 = n_rd; wr0 = n_wr;
    do_flush(10, lat);
    chk("empty_flush_lat", 64'(lat), 64'd1);
    chk("empty_flush_no_mem", 64'((n_rd - rd0) + (n_wr - wr0)), 64'd0);

    // Coalesce a full word then change word.
    rd0 = n_rd; wr0 = n_wr;
    for (int i = 0; i < 8; i++) begin
      send_pixel(10'(16 + i), 10'd2, 8'(8'h10 + i), 10, stalls);
      chk($sformatf("coal_px%0d_stalls", i), 64'(stalls), 64'd0);
    end
    send_pixel(10'd0, 10'd3, 8'h99, 10, stalls);
    chk("coal_change_stalls", 64'(stalls), 64'd2);
    chk("coal_n_rd", 64'(n_rd - rd0), 64'd0);
    chk("coal_n_wr", 64'(n_wr - wr0), 64'd1);
    chk("coal_wr_addr", 64'(last_wr_addr), 64'd162);
    chk("coal_wr_data", last_wr_data, 64'h1011121314151617);

    // Clear while HOLD is dirty (word 240 holds pixel (0,3)).
    wr0 = n_wr; fd0 = n_fd; cd0 = n_cd; fd_at_cd = 1'b0;
    @(negedge Clk); clear_req = 1'b1; clear_index = 8'h07; clr_mon = 1'b1;
    k = 0;
    while (k < 40000) begin
      @(negedge Clk); k++;
      if (clear_done) begin
        fd_at_cd = flush_done;
        break;
      end
      clear_req   = (k == 50);
      clear_index = 8'h55;
      flush_req   = (k == 200);
      px_valid    = (k >= 90 && k <= 110);
      px_x = 10'd5; px_y = 10'd5;
      if (k == 100) begin
        #1;
        chk("clear_px_ready", 64'(px_ready), 64'd0);
        chk("clear_busy", 64'(busy), 64'd1);
      end
    end
    clear_req = 1'b0; flush_req = 1'b0; px_valid = 1'b0;
    chk("clear_done_cycle", 64'(k), 64'd38401);
    chk("clear_idle_at_done", 64'(busy), 64'd0);
    chk("clear_flush_with_done", 64'(fd_at_cd), 64'd1);
    @(negedge Clk); @(negedge Clk); @(negedge Clk);
    clr_mon = 1'b0;
    chk("clear_seq_errors", 64'(clr_bad), 64'd0);
    chk("clear_words", 64'(clr_cnt), 64'd38400);
    chk("clear_n_wr", 64'(n_wr - wr0), 64'd38400);
    chk("clear_n_done", 64'(n_cd - cd0), 64'd1);
    chk("clear_n_flush_done", 64'(n_fd - fd0), 64'd1);
    chk("clear_dirty_word", mem[240], 64'h0707070707070707);
    chk("clear_last_word", mem[38399], 64'h0707070707070707);

    // Out-of-range pixels.
    rd0 = n_rd; wr0 = n_wr;
    send_pixel(10'd640, 10'd0, 8'h11, 10, stalls);
    chk("oor_x_stalls", 64'(stalls), 64'd0);
    chk("oor_x_busy", 64'(busy), 64'd0);
    send_pixel(10'd0, 10'd480, 8'h22, 10, stalls);
    chk("oor_y_stalls", 64'(stalls), 64'd0);
    chk("oor_y_busy", 64'(busy), 64'd0);
    @(negedge Clk);
    chk("oor_busy_later", 64'(busy), 64'd0);
    chk("oor_no_mem", 64'((n_rd - rd0) + (n_wr - wr0)), 64'd0);

    // Last write to a lane wins.
    preload(16'd0, 64'h0123456789ABCDEF);
    send_pixel(10'd0, 10'd0, 8'h01, 10, stalls);
    send_pixel(10'd0, 10'd0, 8'h02, 10, stalls);
    chk("lww_stalls", 64'(stalls), 64'd0);
    do_flush(20, lat);
    @(negedge Clk);
    chk("lww_wr_data", last_wr_data, 64'h0223456789ABCDEF);

    // Reset asserted during RWAIT.
    preload(16'd1, 64'h5555555555555555);
    send_pixel(10'd9, 10'd0, 8'hEE, 10, stalls);
    @(negedge Clk); flush_req = 1'b1;
    @(posedge Clk); #1; flush_req = 1'b0;
    @(negedge Clk);
    chk("rmw_read_strobe", 64'(mem_rd), 64'd1);
    chk("rmw_read_addr", 64'(mem_addr), 64'd1);
    @(negedge Clk);
    Reset = 1'b1; #1;
    wr0 = n_wr;
    chk("midrst_mem_wr", 64'(mem_wr), 64'd0);
    chk("midrst_outputs", 64'({px_ready, busy, mem_rd, flush_done, clear_done}), 64'd0);
    chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
    chk("midrst_mem_wdata", mem_wdata, 64'd0);
    @(negedge Clk); @(negedge Clk); @(negedge Clk);
    Reset = 1'b0; #1;
    chk("midrst_release_px_ready", 64'(px_ready), 64'd0);
    @(negedge Clk);
    chk("midrst_px_ready", 64'(px_ready), 64'd1);
    chk("midrst_no_write", 64'(n_wr - wr0), 64'd0);
    chk("midrst_mem_kept", mem[1], 64'h5555555555555555);

    // Randomized stream over rows 0..3, columns 0..63, with out-of-range strays.
    for (int y = 0; y < 4; y++)
      for (int w = 0; w < 8; w++)
        ref_w[y][w] = mem[y * 80 + w];
    cur_x = '0; cur_y = '0; acc = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge Clk);
      if (acc || !px_valid) begin
        r = $urandom_range(0, 99);
        if (r < 25) begin
          px_valid = 1'b0;
        end else begin
          px_valid = 1'b1;
          if (r < 30) begin
            px_x = 10'(640 + $urandom_range(0, 383)); px_y = 10'($urandom_range(0, 3));
          end else if (r < 34) begin
            px_x = 10'($urandom_range(0, 63)); px_y = 10'(480 + $urandom_range(0, 543));
          end else if (r < 75) begin
            px_x = {cur_x[9:3], 3'($urandom_range(0, 7))}; px_y = cur_y;
          end else begin
            px_x = 10'($urandom_range(0, 63)); px_y = 10'($urandom_range(0, 3));
          end
          if (px_x < 10'd640 && px_y < 10'd480) begin
            cur_x = px_x; cur_y = px_y;
          end
          px_index = 8'($urandom);
        end
      end
      flush_req = ($urandom_range(0, 99) < 4);
      #1;
      acc = px_valid && px_ready;
      if (acc && px_x < 10'd640 && px_y < 10'd480)
        ref_w[px_y[1:0]][px_x[5:3]][8 * (7 - int'(px_x[2:0])) +: 8] = px_index;
    end
    @(negedge Clk); px_valid = 1'b0; flush_req = 1'b0;
    do_flush(20, lat);
    chk("rand_final_flush", 64'(lat >= 1 && lat <= 4), 64'd1);
    @(negedge Clk);
    for (int y = 0; y < 4; y++)
      for (int w = 0; w < 8; w++)
        chk($sformatf("rand_word_%0d", y * 80 + w), mem[y * 80 + w], ref_w[y][w]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
